// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the memory-controller request arbiter.
// Any block that sees the arbiter state or owner fields imports these types.
package mem_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STATE_W = 2;
    localparam logic [2:0] IF_LEN = 3'd4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LSB  = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Grants the byte-serial memory controller to the fetch unit or the load/store buffer.
// LSB has priority, with a starvation guard for IF. Speculative results are dropped on rollback.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              rollback,
    input  logic              if_en,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              if_done,
    output logic [DATA_W-1:0] if_data,
    input  logic              lsb_en,
    input  logic              lsb_wr,
    input  logic [ADDR_W-1:0] lsb_addr,
    input  logic [2:0]        lsb_len,
    input  logic [DATA_W-1:0] lsb_w_data,
    output logic              lsb_done,
    output logic [DATA_W-1:0] lsb_r_data,
    output logic              mc_en,
    output logic              mc_wr,
    output logic [ADDR_W-1:0] mc_addr,
    output logic [2:0]        mc_len,
    output logic [DATA_W-1:0] mc_w_data,
    input  logic              mc_done,
    input  logic [DATA_W-1:0] mc_r_data,
    output state_e            state_dbg
);

    localparam logic [CNT_W-1:0] STARVE_C = CNT_W'(STARVE_MAX);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mc_en_q, mc_en_d, mc_wr_q, mc_wr_d;
    logic [ADDR_W-1:0] mc_addr_q, mc_addr_d;
    logic [2:0]        mc_len_q, mc_len_d;
    logic [DATA_W-1:0] mc_w_data_q, mc_w_data_d;
    logic              if_done_q, if_done_d, lsb_done_q, lsb_done_d;
    logic [DATA_W-1:0] if_data_q, if_data_d, lsb_r_data_q, lsb_r_data_d;
    logic              owner_store;

    assign owner_store = (owner_q == OWN_LSB) && mc_wr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_NONE;
            cnt_q        <= '0;
            mc_en_q      <= 1'b0;
            mc_wr_q      <= 1'b0;
            mc_addr_q    <= '0;
            mc_len_q     <= '0;
            mc_w_data_q  <= '0;
            if_done_q    <= 1'b0;
            lsb_done_q   <= 1'b0;
            if_data_q    <= '0;
            lsb_r_data_q <= '0;
        end else if (rdy) begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            mc_en_q      <= mc_en_d;
            mc_wr_q      <= mc_wr_d;
            mc_addr_q    <= mc_addr_d;
            mc_len_q     <= mc_len_d;
            mc_w_data_q  <= mc_w_data_d;
            if_done_q    <= if_done_d;
            lsb_done_q   <= lsb_done_d;
            if_data_q    <= if_data_d;
            lsb_r_data_q <= lsb_r_data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        mc_en_d      = mc_en_q;
        mc_wr_d      = mc_wr_q;
        mc_addr_d    = mc_addr_q;
        mc_len_d     = mc_len_q;
        mc_w_data_d  = mc_w_data_q;
        if_done_d    = 1'b0;
        lsb_done_d   = 1'b0;
        if_data_d    = if_data_q;
        lsb_r_data_d = lsb_r_data_q;
        case (state_q)
            ST_IDLE: begin
                if (rollback) begin
                    cnt_d = '0;
                end else if (lsb_en && (!if_en || cnt_q < STARVE_C)) begin
                    state_d     = ST_BUSY;
                    owner_d     = OWN_LSB;
                    mc_en_d     = 1'b1;
                    mc_wr_d     = lsb_wr;
                    mc_addr_d   = lsb_addr;
                    mc_len_d    = lsb_len;
                    mc_w_data_d = lsb_w_data;
                    // Count only losses suffered by a waiting fetch; saturate, never wrap.
                    if (!if_en)
                        cnt_d = '0;
                    else if (cnt_q < STARVE_C)
                        cnt_d = cnt_q + CNT_W'(1);
                end else if (if_en) begin
                    state_d     = ST_BUSY;
                    owner_d     = OWN_IF;
                    mc_en_d     = 1'b1;
                    mc_wr_d     = 1'b0;
                    mc_addr_d   = if_pc;
                    mc_len_d    = IF_LEN;
                    mc_w_data_d = '0;
                    cnt_d       = '0;
                end
            end
            ST_BUSY: begin
                if (mc_done) begin
                    state_d = ST_GAP;
                    owner_d = OWN_NONE;
                    mc_en_d = 1'b0;
                    if (owner_store) begin
                        lsb_done_d   = 1'b1;
                        lsb_r_data_d = '0;
                    end else if (!rollback && owner_q == OWN_IF) begin
                        if_done_d = 1'b1;
                        if_data_d = mc_r_data;
                    end else if (!rollback && owner_q == OWN_LSB) begin
                        lsb_done_d   = 1'b1;
                        lsb_r_data_d = mc_r_data;
                    end
                end else if (rollback && !owner_store) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The controller cannot be aborted, so wait out the access silently.
                if (mc_done) begin
                    state_d = ST_GAP;
                    owner_d = OWN_NONE;
                    mc_en_d = 1'b0;
                end
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mc_en      = mc_en_q;
        mc_wr      = mc_wr_q;
        mc_addr    = mc_addr_q;
        mc_len     = mc_len_q;
        mc_w_data  = mc_w_data_q;
        if_done    = if_done_q & rdy;
        lsb_done   = lsb_done_q & rdy;
        if_data    = if_data_q;
        lsb_r_data = lsb_r_data_q;
        state_dbg  = state_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table for single-cycle behaviour plus
// hand-written sequences for store rollback, starvation, async reset and rdy stalls.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rdy, rollback;
    logic        if_en, if_done;
    logic [31:0] if_pc, if_data;
    logic        lsb_en, lsb_wr, lsb_done;
    logic [31:0] lsb_addr, lsb_w_data, lsb_r_data;
    logic [2:0]  lsb_len, mc_len;
    logic        mc_en, mc_wr, mc_done;
    logic [31:0] mc_addr, mc_w_data, mc_r_data;
    state_e      state_dbg;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;

    mem_arbiter #(.STARVE_MAX(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .if_en(if_en), .if_pc(if_pc), .if_done(if_done), .if_data(if_data),
        .lsb_en(lsb_en), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_len(lsb_len),
        .lsb_w_data(lsb_w_data), .lsb_done(lsb_done), .lsb_r_data(lsb_r_data),
        .mc_en(mc_en), .mc_wr(mc_wr), .mc_addr(mc_addr), .mc_len(mc_len),
        .mc_w_data(mc_w_data), .mc_done(mc_done), .mc_r_data(mc_r_data),
        .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    typedef struct {
        logic        rb, ien, len, mdone;
        logic [31:0] rd;
        logic        e_mc_en;
        logic [31:0] e_addr;
        logic        e_if_done, e_lsb_done;
        logic [31:0] e_data;
        state_e      e_st;
    } vec_t;

    vec_t vecs[23];
    logic [31:0] exp_q[$];

    initial begin
        rst = 1'b0; rdy = 1'b1; rollback = 1'b0;
        if_en = 1'b0; if_pc = 32'h1000;
        lsb_en = 1'b0; lsb_wr = 1'b0; lsb_addr = 32'h200; lsb_len = 3'd4; lsb_w_data = 32'h0;
        mc_done = 1'b0; mc_r_data = 32'h0;

        // rb ien len mdone rd | mc_en addr if_done lsb_done data state
        vecs[0]  = '{0,0,0,0,32'h0,        0,32'h0,   0,0,32'h0,        ST_IDLE};
        vecs[1]  = '{0,1,0,0,32'h0,        1,32'h1000,0,0,32'h0,        ST_BUSY};
        vecs[2]  = '{0,1,0,0,32'h0,        1,32'h1000,0,0,32'h0,        ST_BUSY};
        vecs[3]  = '{0,1,0,1,32'hDEADBEEF, 0,32'h0,   1,0,32'hDEADBEEF, ST_GAP};
        vecs[4]  = '{0,0,0,0,32'h0,        0,32'h0,   0,0,32'h0,        ST_IDLE};
        vecs[5]  = '{0,0,1,0,32'h0,        1,32'h200, 0,0,32'h0,        ST_BUSY};
        vecs[6]  = '{0,0,0,1,32'h12345678, 0,32'h0,   0,1,32'h12345678, ST_GAP};
        vecs[7]  = '{0,0,0,0,32'h0,        0,32'h0,   0,0,32'h0,        ST_IDLE};
        vecs[8]  = '{1,0,1,0,32'h0,        0,32'h0,   0,0,32'h0,        ST_IDLE};
        vecs[9]  = '{0,0,1,0,32'h0,        1,32'h200, 0,0,32'h0,        ST_BUSY};
        vecs[10] = '{1,0,0,0,32'h0,        1,32'h200, 0,0,32'h0,        ST_DRAIN};
        vecs[11] = '{1,0,0,0,32'h0,        1,32'h200, 0,0,32'h0,        ST_DRAIN};
        vecs[12] = '{0,0,0,1,32'h55AA55AA, 0,32'h0,   0,0,32'h0,        ST_GAP};
        vecs[13] = '{1,0,0,0,32'h0,        0,32'h0,   0,0,32'h0,        ST_IDLE};
        vecs[14] = '{0,1,0,0,32'h0,        1,32'h1000,0,0,32'h0,        ST_BUSY};
        vecs[15] = '{1,0,0,1,32'hCAFEF00D, 0,32'h0,   0,0,32'h0,        ST_GAP};
        vecs[16] = '{0,0,0,0,32'h0,        0,32'h0,   0,0,32'h0,        ST_IDLE};
        vecs[17] = '{0,1,1,0,32'h0,        1,32'h200, 0,0,32'h0,        ST_BUSY};
        vecs[18] = '{0,1,0,1,32'h0BADF00D, 0,32'h0,   0,1,32'h0BADF00D, ST_GAP};
        vecs[19] = '{0,1,0,0,32'h0,        0,32'h0,   0,0,32'h0,        ST_IDLE};
        vecs[20] = '{0,1,0,0,32'h0,        1,32'h1000,0,0,32'h0,        ST_BUSY};
        vecs[21] = '{0,0,0,1,32'h11112222, 0,32'h0,   1,0,32'h11112222, ST_GAP};
        vecs[22] = '{0,0,0,0,32'h0,        0,32'h0,   0,0,32'h0,        ST_IDLE};

        // reset state
        tick();
        chk("rst mc_en", 32'(mc_en), 32'h0);
        chk("rst mc_addr", mc_addr, 32'h0);
        chk("rst if_done", 32'(if_done), 32'h0);
        chk("rst lsb_done", 32'(lsb_done), 32'h0);
        chk("rst state", 32'(state_dbg), 32'(ST_IDLE));
        rst = 1'b1;

        // vector table
        for (int i = 0; i < 23; i++) begin
            rollback  = vecs[i].rb;
            if_en     = vecs[i].ien;
            lsb_en    = vecs[i].len;
            mc_done   = vecs[i].mdone;
            mc_r_data = vecs[i].rd;
            tick();
            chk($sformatf("v%0d mc_en", i), 32'(mc_en), 32'(vecs[i].e_mc_en));
            chk($sformatf("v%0d if_done", i), 32'(if_done), 32'(vecs[i].e_if_done));
            chk($sformatf("v%0d lsb_done", i), 32'(lsb_done), 32'(vecs[i].e_lsb_done));
            chk($sformatf("v%0d state", i), 32'(state_dbg), 32'(vecs[i].e_st));
            if (vecs[i].e_mc_en)
                chk($sformatf("v%0d mc_addr", i), mc_addr, vecs[i].e_addr);
            if (vecs[i].e_if_done)
                chk($sformatf("v%0d if_data", i), if_data, vecs[i].e_data);
            if (vecs[i].e_lsb_done)
                chk($sformatf("v%0d lsb_r_data", i), lsb_r_data, vecs[i].e_data);
            if (vecs[i].e_mc_en && vecs[i].e_addr == 32'h1000) begin
                chk($sformatf("v%0d if mc_len", i), 32'(mc_len), 32'd4);
                chk($sformatf("v%0d if mc_wr", i), 32'(mc_wr), 32'd0);
            end
        end
        rollback = 1'b0; if_en = 1'b0; lsb_en = 1'b0; mc_done = 1'b0;

        // store survives rollback
        lsb_en = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h30004; lsb_len = 3'd1; lsb_w_data = 32'hAB;
        tick();
        chk("st mc_en", 32'(mc_en), 32'd1);
        chk("st mc_wr", 32'(mc_wr), 32'd1);
        chk("st mc_addr", mc_addr, 32'h30004);
        chk("st mc_len", 32'(mc_len), 32'd1);
        chk("st mc_w_data", mc_w_data, 32'hAB);
        lsb_en = 1'b0; lsb_addr = 32'h0; lsb_w_data = 32'h0;
        tick();
        rollback = 1'b1;
        tick();
        rollback = 1'b0;
        chk("st rb state", 32'(state_dbg), 32'(ST_BUSY));
        chk("st rb mc_addr", mc_addr, 32'h30004);
        mc_done = 1'b1; mc_r_data = 32'hFFFFFFFF;
        tick();
        mc_done = 1'b0;
        chk("st lsb_done", 32'(lsb_done), 32'd1);
        chk("st lsb_r_data", lsb_r_data, 32'h0);
        chk("st if_done", 32'(if_done), 32'd0);
        tick();
        chk("st idle", 32'(state_dbg), 32'(ST_IDLE));

        // starvation guard: both requesters held
        do_reset();
        lsb_wr = 1'b0; lsb_addr = 32'h400; lsb_len = 3'd4;
        exp_q = {32'h400, 32'h400, 32'h400, 32'h400, 32'h1000, 32'h400};
        if_en = 1'b1; lsb_en = 1'b1;
        begin
            int done_cyc;
            bit seen;
            done_cyc = cyc;
            for (int g = 0; g < 6; g++) begin
                seen = 1'b0;
                for (int w = 0; w < 8 && !seen; w++) begin
                    tick();
                    seen = mc_en;
                end
                chk($sformatf("sv g%0d granted", g), 32'(seen), 32'd1);
                chk($sformatf("sv g%0d owner", g), mc_addr, exp_q.pop_front());
                if (g > 0)
                    chk($sformatf("sv g%0d gap>=2", g), 32'(cyc - done_cyc >= 2), 32'd1);
                mc_done = 1'b1; mc_r_data = 32'(g);
                tick();
                mc_done = 1'b0;
                done_cyc = cyc;
            end
        end
        if_en = 1'b0; lsb_en = 1'b0;
        tick();
        tick();

        // asynchronous reset mid-transfer
        if_pc = 32'h2000; if_en = 1'b1;
        tick();
        chk("ar busy mc_en", 32'(mc_en), 32'd1);
        if_en = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("ar mc_en", 32'(mc_en), 32'd0);
        chk("ar if_done", 32'(if_done), 32'd0);
        chk("ar lsb_done", 32'(lsb_done), 32'd0);
        chk("ar state", 32'(state_dbg), 32'(ST_IDLE));
        tick();
        rst = 1'b1;
        if_pc = 32'h3000; if_en = 1'b1;
        tick();
        chk("ar regrant mc_en", 32'(mc_en), 32'd1);
        chk("ar regrant addr", mc_addr, 32'h3000);

        // rdy stall during BUSY
        if_en = 1'b0; if_pc = 32'h0;
        rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("rdy k%0d mc_en", k), 32'(mc_en), 32'd1);
            chk($sformatf("rdy k%0d mc_addr", k), mc_addr, 32'h3000);
            chk($sformatf("rdy k%0d if_done", k), 32'(if_done), 32'd0);
        end
        rdy = 1'b1; mc_done = 1'b1; mc_r_data = 32'h0A0B0C0D;
        tick();
        mc_done = 1'b0;
        chk("rdy done", 32'(if_done), 32'd1);
        chk("rdy data", if_data, 32'h0A0B0C0D);
        rdy = 1'b0;
        tick();
        chk("rdy masked done", 32'(if_done), 32'd0);
        chk("rdy frozen state", 32'(state_dbg), 32'(ST_GAP));
        rdy = 1'b1;
        #1;
        chk("rdy resumed done", 32'(if_done), 32'd1);
        tick();
        chk("rdy end done", 32'(if_done), 32'd0);
        chk("rdy end state", 32'(state_dbg), 32'(ST_IDLE));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
